// File: rtl/zmod_pll_ctrl.sv
// PLL supervisor: pulses PLL reset, qualifies lock with stability window/timeout/retries, then releases staggered domain resets.
// Optional lock-loss counter built only when ZMOD_PLL_CTRL_LOSS_CNT_EN is defined; otherwise lost_cnt is tied to 0.
module zmod_pll_ctrl #(
  parameter int NUM_OUT             = 2,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRY           = 3,
  parameter int CNT_W               = 8
) (
  input  logic               clkin,
  input  logic               rstn,
  input  logic               enable,
  input  logic               restart,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               ready,
  output logic               fail,
  output logic [CNT_W-1:0]   lost_cnt,
  output logic [2:0]         state
);

  localparam int PW  = $clog2(RST_PULSE_CYCLES + 1);
  localparam int SW  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW  = $clog2(LOCK_TIMEOUT_CYCLES);
  localparam int RLW = $clog2(NUM_OUT * STAGGER_CYCLES + 1);
  localparam int RTW = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0]  PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0]  STAB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RLW-1:0] REL_LAST   = RLW'(NUM_OUT * STAGGER_CYCLES);
  localparam logic [RTW-1:0] RETRY_LAST = RTW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RELEASE   = 3'd4,
    S_RUN       = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  state_t           st;
  logic             locked_m;
  logic             locked_s;
  logic [PW-1:0]    pulse_cnt;
  logic [SW-1:0]    stab_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [RLW-1:0]   rel_cnt;
  logic [RLW-1:0]   rel_inc;
  logic [RTW-1:0]   retry_cnt;
  logic [NUM_OUT-1:0] rel_mask;

  assign state   = st;
  assign rel_inc = rel_cnt + 1'b1;

  // Bit i is released once (i+1)*STAGGER_CYCLES cycles have elapsed in RELEASE.
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < NUM_OUT; i++)
      rel_mask[i] = (rel_inc >= RLW'((i + 1) * STAGGER_CYCLES));
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      st        <= S_IDLE;
      locked_m  <= 1'b0;
      locked_s  <= 1'b0;
      pulse_cnt <= '0;
      stab_cnt  <= '0;
      tmo_cnt   <= '0;
      rel_cnt   <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      rst_out_n <= '0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      locked_m  <= pll_locked;
      locked_s  <= locked_m;
      // Outputs default to the "held in reset" values; run states override.
      pll_rst   <= 1'b1;
      rst_out_n <= '0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      if (!enable) begin
        st        <= S_IDLE;
        retry_cnt <= '0;
      end else if (restart) begin
        st        <= S_RESET;
        pulse_cnt <= '0;
        if (st == S_FAIL) retry_cnt <= '0;
      end else begin
        case (st)
          S_IDLE: begin
            st        <= S_RESET;
            pulse_cnt <= '0;
          end
          S_RESET: begin
            if (pulse_cnt == PULSE_LAST) begin
              st      <= S_WAIT_LOCK;
              tmo_cnt <= '0;
              pll_rst <= 1'b0;
            end else begin
              pulse_cnt <= pulse_cnt + 1'b1;
            end
          end
          S_WAIT_LOCK, S_STABLE: begin
            if (tmo_cnt == TMO_LAST) begin
              retry_cnt <= retry_cnt + 1'b1;
              pulse_cnt <= '0;
              if (retry_cnt == RETRY_LAST) begin
                st   <= S_FAIL;
                fail <= 1'b1;
              end else begin
                st <= S_RESET;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
              pll_rst <= 1'b0;
              if (st == S_WAIT_LOCK) begin
                if (locked_s) begin
                  st       <= S_STABLE;
                  stab_cnt <= '0;
                end
              end else if (!locked_s) begin
                st <= S_WAIT_LOCK;
              end else if (stab_cnt == STAB_LAST) begin
                st        <= S_RELEASE;
                retry_cnt <= '0;
                rel_cnt   <= '0;
              end else begin
                stab_cnt <= stab_cnt + 1'b1;
              end
            end
          end
          S_RELEASE: begin
            if (!locked_s) begin
              st        <= S_RESET;
              pulse_cnt <= '0;
            end else if (rel_cnt == REL_LAST) begin
              st        <= S_RUN;
              pll_rst   <= 1'b0;
              rst_out_n <= '1;
              ready     <= 1'b1;
            end else begin
              rel_cnt   <= rel_inc;
              pll_rst   <= 1'b0;
              rst_out_n <= rel_mask;
            end
          end
          S_RUN: begin
            if (!locked_s) begin
              st        <= S_RESET;
              pulse_cnt <= '0;
            end else begin
              pll_rst   <= 1'b0;
              rst_out_n <= '1;
              ready     <= 1'b1;
            end
          end
          S_FAIL: begin
            fail <= 1'b1;
          end
          default: begin
            st <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef ZMOD_PLL_CTRL_LOSS_CNT_EN
  logic lost_inc;

  // Lock loss only counts when neither disable nor restart preempts it.
  assign lost_inc = enable && !restart && !locked_s &&
                    ((st == S_RELEASE) || (st == S_RUN));

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn)
      lost_cnt <= '0;
    else if (lost_inc && (lost_cnt != {CNT_W{1'b1}}))
      lost_cnt <= lost_cnt + 1'b1;
  end
`else
  assign lost_cnt = '0;
`endif

endmodule
